dac_spi_receiver: RTL and testbench
===================================

Name: dac_spi_receiver

Overview:
- LTC2624-compatible SPI slave: the responder end of the DAC serial link driven by the DAC driver.
- Oversamples SPI_SCK, DAC_CS, SPI_MOSI and DAC_CLR on CLK_50M and deserialises 32-bit frames.
- Decodes command and address, and maintains per-channel input and output registers for channels A–D.
- Used as an on-chip loopback/monitor and as the bench model for the ADC→DAC relay, delay and differentiator paths.

Parameters:
- FRAME_BITS, 32, bits per valid frame.
- DATA_BITS, 12, DAC code width; data field = word[15:16-DATA_BITS].
- SYNC_STAGES, 2, synchroniser depth on all four SPI inputs.

Ports:
- CLK_50M  in  1  system clock.
- RESET_N  in  1  synchronous active-low reset.
- SPI_SCK  in  1  serial clock from master (async to logic, sampled).
- SPI_MOSI  in  1  serial data, MSB first, valid at SCK rising edge.
- DAC_CS  in  1  active-low frame select.
- DAC_CLR  in  1  active-low asynchronous-at-pin clear, sampled via synchroniser.
- dac_a  out  DATA_BITS  channel A output register.
- dac_b  out  DATA_BITS  channel B output register.
- dac_c  out  DATA_BITS  channel C output register.
- dac_d  out  DATA_BITS  channel D output register.
- pd_mask  out  4  per-channel power-down flags [D:A].
- frame_valid  out  1  one-cycle strobe when a good frame commits.
- frame_cmd  out  4  last committed command.
- frame_addr  out  4  last committed address.
- frame_data  out  DATA_BITS  last committed data field.
- frame_err  out  1  one-cycle strobe on a malformed frame.

Behaviour:
- Reset (RESET_N low at CLK_50M edge):
  - all outputs, input registers, shift register and bit counter go to 0; pd_mask=0; FSM→IDLE.
  - Reset overrides any frame in progress; the partial frame is discarded, no strobe.
- Synchronisers: SYNC_STAGES flops per input, plus one history flop on SCK and CS for edge detection.
- Timing constraint on the master: SCK high and low phases each ≥ SYNC_STAGES+2 CLK_50M cycles.
- Word format, MSB first:
  - word[31:24] don't care.
  - word[23:20] cmd.
  - word[19:16] addr.
  - word[15:4] data.
  - word[3:0] don't care.
- FSM:
  - IDLE: synced CS high. CS falling edge → SHIFT; clear count and shift register.
  - SHIFT: on each synced SCK rising edge with CS low, shift in the synced MOSI and increment count. count reaching FRAME_BITS → FULL.
  - FULL: any further SCK rising edge sets an internal overflow flag; the shift register is not modified.
  - On CS rising edge from SHIFT or FULL → COMMIT for one cycle, then IDLE.
- COMMIT:
  - count==FRAME_BITS and no overflow: frame_valid=1 for exactly one cycle; frame_cmd/addr/data load in the same cycle; the command executes in the same cycle.
  - Otherwise (short or long frame): frame_err=1 for one cycle; no register or frame_* change.
- Latency: frame_valid asserts SYNC_STAGES+2 CLK_50M cycles after the DAC_CS pin rises.
- Commands (ch = addr 0..3 → A..D; addr 4'hF → all four; other addr → no channel affected, frame_valid still pulses):
  - 0000: input[ch] ← data.
  - 0001: out[ch] ← input[ch]; pd[ch] ← 0.
  - 0010: input[ch] ← data, then every out ← its input; all pd ← 0.
  - 0011: input[ch] ← data; out[ch] ← data; pd[ch] ← 0.
  - 0100: pd[ch] ← 1; out[ch] unchanged.
  - 1111: no-op.
  - Other codes: no-op.
- DAC_CLR synced low: all input and output registers ← 0 on every cycle it is held low. pd_mask is unchanged. Clear wins over a simultaneous COMMIT, but frame_valid and frame_* still update.
- SCK edges while CS high are ignored.
- A CS glitch shorter than the synchroniser may be missed; this is acceptable.

Test Plan:
- Frame 32'h0030_ABC0 (cmd 3, addr 0, data ABC) → dac_a=12'hABC; frame_valid pulses 1 cycle; frame_cmd=3, frame_addr=0.
- Frame 32'h0001_1230 (cmd 0, B, 123) → dac_b stays 0. Then frame 32'h0011_0000 (cmd 1, B) → dac_b=12'h123.
- Frame 32'h003F_8000 (cmd 3, all, 800) → dac_a..d all =12'h800. Then frame 32'h0042_0000 (cmd 4, C) → pd_mask=4'b0100, dac_c still 800.
- CS low for 20 SCKs then high → frame_err pulse; no frame_valid; registers unchanged. Same for 33 SCKs.
- DAC_CLR pulsed low (≥3 cycles) after loading all channels → all dac_* =0; pd_mask unchanged.
- RESET_N low at bit 17 of a frame, released, then a full 32'h0033_5550 frame → only the new frame commits: dac_d=12'h555, no frame_err.

Source files
------------

// File: rtl/dac_spi_receiver.sv
// ---------------------------------------------------------------------------
// dac_spi_receiver
//   LTC2624-compatible SPI slave. Oversamples the serial link on CLK_50M,
//   deserialises 32-bit frames, decodes cmd/addr/data and keeps per-channel
//   input and output registers for channels A..D.
//
// Ports
//   CLK_50M      system clock
//   RESET_N      synchronous active-low reset
//   SPI_SCK      serial clock from the master (asynchronous, oversampled)
//   SPI_MOSI     serial data, MSB first, valid at SCK rising edge
//   DAC_CS       active-low frame select
//   DAC_CLR      active-low clear (synchronised)
//   dac_a..dac_d channel output registers
//   pd_mask      per-channel power-down flags [D:A]
//   frame_valid  one-cycle strobe when a good frame commits
//   frame_cmd    last committed command
//   frame_addr   last committed address
//   frame_data   last committed data field
//   frame_err    one-cycle strobe on a short or long frame
// ---------------------------------------------------------------------------
module dac_spi_receiver #(
    parameter int FRAME_BITS  = 32,
    parameter int DATA_BITS   = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 CLK_50M,
    input  logic                 RESET_N,
    input  logic                 SPI_SCK,
    input  logic                 SPI_MOSI,
    input  logic                 DAC_CS,
    input  logic                 DAC_CLR,
    output logic [DATA_BITS-1:0] dac_a,
    output logic [DATA_BITS-1:0] dac_b,
    output logic [DATA_BITS-1:0] dac_c,
    output logic [DATA_BITS-1:0] dac_d,
    output logic [3:0]           pd_mask,
    output logic                 frame_valid,
    output logic [3:0]           frame_cmd,
    output logic [3:0]           frame_addr,
    output logic [DATA_BITS-1:0] frame_data,
    output logic                 frame_err
);

    localparam int               CNT_W    = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FULL, COMMIT} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sck_p0, cs_p0, mosi_p0, clr_p0;
    logic                   sck_p1, cs_p1;
    logic                   sck_s, cs_s, mosi_s, clr_s;
    logic                   sck_rise, cs_fall, cs_rise;

    logic [FRAME_BITS-1:0]  shreg;
    logic [CNT_W-1:0]       count;
    logic                   ovf;
    logic                   commit_ok;

    logic [3:0]             w_cmd, w_addr;
    logic [DATA_BITS-1:0]   w_data;
    logic [3:0]             hit;

    logic [DATA_BITS-1:0]   in_reg  [4];
    logic [DATA_BITS-1:0]   out_reg [4];
    logic [DATA_BITS-1:0]   in_nxt  [4];
    logic [DATA_BITS-1:0]   out_nxt [4];
    logic [3:0]             pd_nxt;

    logic                   unused_bits;

    // Synchroniser stage: the chains are deliberately not reset so they keep
    // tracking the pins while RESET_N is low; a master that raises CS during
    // reset then produces no spurious edge at release.
    always_ff @(posedge CLK_50M) begin
        sck_p0  <= {sck_p0[SYNC_STAGES-2:0],  SPI_SCK};
        cs_p0   <= {cs_p0[SYNC_STAGES-2:0],   DAC_CS};
        mosi_p0 <= {mosi_p0[SYNC_STAGES-2:0], SPI_MOSI};
        clr_p0  <= {clr_p0[SYNC_STAGES-2:0],  DAC_CLR};
        sck_p1  <= sck_p0[SYNC_STAGES-1];
        cs_p1   <= cs_p0[SYNC_STAGES-1];
    end

    assign sck_s  = sck_p0[SYNC_STAGES-1];
    assign cs_s   = cs_p0[SYNC_STAGES-1];
    assign mosi_s = mosi_p0[SYNC_STAGES-1];
    assign clr_s  = clr_p0[SYNC_STAGES-1];

    // SCK edges are only meaningful while the frame is selected.
    assign sck_rise = sck_s & ~sck_p1 & ~cs_s;
    assign cs_fall  = ~cs_s & cs_p1;
    assign cs_rise  = cs_s & ~cs_p1;

    assign w_cmd     = shreg[23:20];
    assign w_addr    = shreg[19:16];
    assign w_data    = shreg[15 -: DATA_BITS];
    assign commit_ok = (state == COMMIT) && (count == CNT_FULL) && !ovf;

    assign unused_bits = ^{shreg[FRAME_BITS-1:24], shreg[15-DATA_BITS:0]};

    always_ff @(posedge CLK_50M) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = SHIFT;
            SHIFT: begin
                if (cs_rise)                              state_nxt = COMMIT;
                else if (sck_rise && (count == CNT_LAST)) state_nxt = FULL;
            end
            FULL:    if (cs_rise) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command decode. Address 4'hF selects every channel; other
    // out-of-range addresses select none.
    always_comb begin
        for (int ch = 0; ch < 4; ch++)
            hit[ch] = (w_addr == 4'(ch)) || (w_addr == 4'hF);
    end

    always_comb begin
        in_nxt  = in_reg;
        out_nxt = out_reg;
        pd_nxt  = pd_mask;
        if (commit_ok) begin
            case (w_cmd)
                4'b0000: for (int ch = 0; ch < 4; ch++)
                    if (hit[ch]) in_nxt[ch] = w_data;
                4'b0001: for (int ch = 0; ch < 4; ch++)
                    if (hit[ch]) begin
                        out_nxt[ch] = in_reg[ch];
                        pd_nxt[ch]  = 1'b0;
                    end
                4'b0010: begin
                    // Write the addressed input first, then update every
                    // output from the freshly written inputs.
                    for (int ch = 0; ch < 4; ch++)
                        if (hit[ch]) in_nxt[ch] = w_data;
                    for (int ch = 0; ch < 4; ch++)
                        out_nxt[ch] = in_nxt[ch];
                    pd_nxt = 4'b0000;
                end
                4'b0011: for (int ch = 0; ch < 4; ch++)
                    if (hit[ch]) begin
                        in_nxt[ch]  = w_data;
                        out_nxt[ch] = w_data;
                        pd_nxt[ch]  = 1'b0;
                    end
                4'b0100: for (int ch = 0; ch < 4; ch++)
                    if (hit[ch]) pd_nxt[ch] = 1'b1;
                default: ;
            endcase
        end
        // Clear dominates any simultaneous command; pd_mask is left alone.
        if (!clr_s) begin
            for (int ch = 0; ch < 4; ch++) begin
                in_nxt[ch]  = '0;
                out_nxt[ch] = '0;
            end
        end
    end

    // Frame capture / commit stage
    always_ff @(posedge CLK_50M) begin
        if (!RESET_N) begin
            shreg       <= '0;
            count       <= '0;
            ovf         <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_cmd   <= '0;
            frame_addr  <= '0;
            frame_data  <= '0;
            pd_mask     <= '0;
            for (int ch = 0; ch < 4; ch++) begin
                in_reg[ch]  <= '0;
                out_reg[ch] <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                IDLE: if (cs_fall) begin
                    shreg <= '0;
                    count <= '0;
                    ovf   <= 1'b0;
                end
                SHIFT: if (sck_rise) begin
                    shreg <= {shreg[FRAME_BITS-2:0], mosi_s};
                    count <= count + 1'b1;
                end
                FULL: if (sck_rise) ovf <= 1'b1;
                COMMIT: begin
                    if (commit_ok) begin
                        frame_valid <= 1'b1;
                        frame_cmd   <= w_cmd;
                        frame_addr  <= w_addr;
                        frame_data  <= w_data;
                    end else begin
                        frame_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
            in_reg  <= in_nxt;
            out_reg <= out_nxt;
            pd_mask <= pd_nxt;
        end
    end

    assign dac_a = out_reg[0];
    assign dac_b = out_reg[1];
    assign dac_c = out_reg[2];
    assign dac_d = out_reg[3];

endmodule

// File: tb/tb_dac_spi_receiver.sv
// ---------------------------------------------------------------------------
// tb_dac_spi_receiver
//   Self-checking bench for dac_spi_receiver. Drives SPI frames bit by bit,
//   keeps a behavioural model of the DAC register file and compares outputs
//   on the falling edge of CLK_50M.
// ---------------------------------------------------------------------------
module tb_dac_spi_receiver;

    localparam int H = 6;   // SCK half-period in CLK_50M cycles

    logic        CLK_50M = 1'b0;
    logic        RESET_N, SPI_SCK, SPI_MOSI, DAC_CS, DAC_CLR;
    logic [11:0] dac_a, dac_b, dac_c, dac_d, frame_data;
    logic [3:0]  pd_mask, frame_cmd, frame_addr;
    logic        frame_valid, frame_err;

    logic [11:0] dac_arr [4];
    assign dac_arr[0] = dac_a;
    assign dac_arr[1] = dac_b;
    assign dac_arr[2] = dac_c;
    assign dac_arr[3] = dac_d;

    dac_spi_receiver dut (
        .CLK_50M    (CLK_50M),
        .RESET_N    (RESET_N),
        .SPI_SCK    (SPI_SCK),
        .SPI_MOSI   (SPI_MOSI),
        .DAC_CS     (DAC_CS),
        .DAC_CLR    (DAC_CLR),
        .dac_a      (dac_a),
        .dac_b      (dac_b),
        .dac_c      (dac_c),
        .dac_d      (dac_d),
        .pd_mask    (pd_mask),
        .frame_valid(frame_valid),
        .frame_cmd  (frame_cmd),
        .frame_addr (frame_addr),
        .frame_data (frame_data),
        .frame_err  (frame_err)
    );

    always #10 CLK_50M = ~CLK_50M;

    int n_cmp = 0;
    int n_bad = 0;
    int err_seen = 0;
    always @(negedge CLK_50M) if (frame_err === 1'b1) err_seen++;

    // Behavioural model of the DAC register file
    logic [11:0] in_m  [4];
    logic [11:0] out_m [4];
    logic [3:0]  pd_m;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            in_m[i]  = '0;
            out_m[i] = '0;
        end
        pd_m = '0;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) begin
            in_m[i]  = '0;
            out_m[i] = '0;
        end
    endfunction

    function automatic void model_apply(input logic [31:0] w);
        logic [3:0]  c, a;
        logic [11:0] d;
        c = w[23:20];
        a = w[19:16];
        d = w[15:4];
        for (int i = 0; i < 4; i++) begin
            if (a == 4'(i) || a == 4'hF) begin
                if (c == 4'd0 || c == 4'd2 || c == 4'd3) in_m[i] = d;
                if (c == 4'd1) out_m[i] = in_m[i];
                if (c == 4'd3) out_m[i] = d;
                if (c == 4'd1 || c == 4'd3) pd_m[i] = 1'b0;
                if (c == 4'd4) pd_m[i] = 1'b1;
            end
        end
        if (c == 4'd2) begin
            for (int i = 0; i < 4; i++) out_m[i] = in_m[i];
            pd_m = 4'b0000;
        end
    endfunction

    task automatic clk_n(input int n);
        repeat (n) @(negedge CLK_50M);
    endtask

    // Sends nbits (MSB first; bits past 32 are zero) and then watches
    // `window` cycles after CS rises, counting strobe samples.
    task automatic send_frame(input logic [31:0] w, input int nbits, input int window,
                              output int nv, output int ne, output int lat);
        DAC_CS = 1'b0;
        clk_n(H);
        for (int i = 0; i < nbits; i++) begin
            SPI_MOSI = (i < 32) ? w[31-i] : 1'b0;
            clk_n(H);
            SPI_SCK = 1'b1;
            clk_n(H);
            SPI_SCK = 1'b0;
        end
        clk_n(H);
        DAC_CS = 1'b1;
        nv = 0; ne = 0; lat = -1;
        for (int k = 1; k <= window; k++) begin
            @(negedge CLK_50M);
            if (frame_valid === 1'b1) begin
                nv++;
                if (lat < 0) lat = k;
            end
            if (frame_err === 1'b1) ne++;
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; SPI_SCK = 1'b0; SPI_MOSI = 1'b0; DAC_CS = 1'b1; DAC_CLR = 1'b1;
        model_reset();
        clk_n(10);
        RESET_N = 1'b1;
        clk_n(6);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dac_arr[i] !== 12'h000) begin
                n_bad++; $display("FAIL reset_dac%0d: got %h want %h", i, dac_arr[i], 12'h000);
            end
        end
        n_cmp++;
        if ({pd_mask, frame_cmd, frame_addr, frame_data, frame_valid, frame_err} !== 26'd0) begin
            n_bad++; $display("FAIL reset_misc: pd=%b cmd=%h addr=%h data=%h vld=%b err=%b want all 0",
                              pd_mask, frame_cmd, frame_addr, frame_data, frame_valid, frame_err);
        end
    endtask

    task automatic test_write_update();
        int nv, ne, lat;
        model_apply(32'h0030_ABC0);
        send_frame(32'h0030_ABC0, 32, 12, nv, ne, lat);
        n_cmp++;
        if (nv !== 1 || ne !== 0) begin
            n_bad++; $display("FAIL wu_strobes: valid=%0d err=%0d want 1/0", nv, ne);
        end
        n_cmp++;
        if (lat !== 4) begin
            n_bad++; $display("FAIL wu_latency: got %0d want 4", lat);
        end
        n_cmp++;
        if (dac_a !== 12'hABC) begin
            n_bad++; $display("FAIL wu_dac_a: got %h want ABC", dac_a);
        end
        n_cmp++;
        if (frame_cmd !== 4'h3 || frame_addr !== 4'h0 || frame_data !== 12'hABC) begin
            n_bad++; $display("FAIL wu_frame: cmd=%h addr=%h data=%h want 3/0/ABC",
                              frame_cmd, frame_addr, frame_data);
        end
    endtask

    task automatic test_input_then_update();
        int nv, ne, lat;
        model_apply(32'h0001_1230);
        send_frame(32'h0001_1230, 32, 12, nv, ne, lat);
        n_cmp++;
        if (dac_b !== 12'h000 || nv !== 1) begin
            n_bad++; $display("FAIL in_only: dac_b=%h valid=%0d want 000/1", dac_b, nv);
        end
        model_apply(32'h0011_0000);
        send_frame(32'h0011_0000, 32, 12, nv, ne, lat);
        n_cmp++;
        if (dac_b !== 12'h123) begin
            n_bad++; $display("FAIL update_b: got %h want 123", dac_b);
        end
    endtask

    task automatic test_all_powerdown();
        int nv, ne, lat;
        model_apply(32'h003F_8000);
        send_frame(32'h003F_8000, 32, 12, nv, ne, lat);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dac_arr[i] !== 12'h800) begin
                n_bad++; $display("FAIL all_dac%0d: got %h want 800", i, dac_arr[i]);
            end
        end
        model_apply(32'h0042_0000);
        send_frame(32'h0042_0000, 32, 12, nv, ne, lat);
        n_cmp++;
        if (pd_mask !== 4'b0100 || dac_c !== 12'h800) begin
            n_bad++; $display("FAIL pd_c: pd=%b dac_c=%h want 0100/800", pd_mask, dac_c);
        end
    endtask

    task automatic test_bad_frames();
        int nv, ne, lat;
        logic [3:0] cmd_before;
        cmd_before = frame_cmd;
        send_frame(32'h0033_1110, 20, 12, nv, ne, lat);
        n_cmp++;
        if (ne !== 1 || nv !== 0) begin
            n_bad++; $display("FAIL short_strobes: err=%0d valid=%0d want 1/0", ne, nv);
        end
        send_frame(32'h0030_1110, 33, 12, nv, ne, lat);
        n_cmp++;
        if (ne !== 1 || nv !== 0) begin
            n_bad++; $display("FAIL long_strobes: err=%0d valid=%0d want 1/0", ne, nv);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dac_arr[i] !== out_m[i]) begin
                n_bad++; $display("FAIL bad_dac%0d: got %h want %h", i, dac_arr[i], out_m[i]);
            end
        end
        n_cmp++;
        if (frame_cmd !== cmd_before || pd_mask !== pd_m) begin
            n_bad++; $display("FAIL bad_hold: cmd=%h pd=%b want %h/%b", frame_cmd, pd_mask, cmd_before, pd_m);
        end
    endtask

    task automatic test_clear();
        int nv, ne, lat;
        model_apply(32'h003F_7770);
        send_frame(32'h003F_7770, 32, 12, nv, ne, lat);
        model_apply(32'h0043_0000);
        send_frame(32'h0043_0000, 32, 12, nv, ne, lat);
        DAC_CLR = 1'b0;
        clk_n(5);
        DAC_CLR = 1'b1;
        clk_n(5);
        model_clear();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dac_arr[i] !== 12'h000) begin
                n_bad++; $display("FAIL clr_dac%0d: got %h want 000", i, dac_arr[i]);
            end
        end
        n_cmp++;
        if (pd_mask !== 4'b1000) begin
            n_bad++; $display("FAIL clr_pd: got %b want 1000", pd_mask);
        end
        // Updating A from its input register must now yield zero.
        model_apply(32'h0010_0000);
        send_frame(32'h0010_0000, 32, 12, nv, ne, lat);
        n_cmp++;
        if (dac_a !== 12'h000 || nv !== 1) begin
            n_bad++; $display("FAIL clr_input: dac_a=%h valid=%0d want 000/1", dac_a, nv);
        end
    endtask

    task automatic test_reset_midframe();
        int nv, ne, lat, err0;
        logic [31:0] w;
        w = 32'h0030_FFF0;
        err0 = err_seen;
        DAC_CS = 1'b0;
        clk_n(H);
        for (int i = 0; i < 17; i++) begin
            SPI_MOSI = w[31-i];
            clk_n(H);
            SPI_SCK = 1'b1;
            clk_n(H);
            SPI_SCK = 1'b0;
        end
        RESET_N = 1'b0;
        clk_n(2);
        DAC_CS = 1'b1;
        clk_n(8);
        RESET_N = 1'b1;
        clk_n(8);
        model_reset();
        n_cmp++;
        if (err_seen !== err0 || dac_a !== 12'h000 || pd_mask !== 4'b0000) begin
            n_bad++; $display("FAIL rst_mid: errs=%0d dac_a=%h pd=%b want %0d/000/0000",
                              err_seen, dac_a, pd_mask, err0);
        end
        model_apply(32'h0033_5550);
        send_frame(32'h0033_5550, 32, 12, nv, ne, lat);
        n_cmp++;
        if (dac_d !== 12'h555 || nv !== 1 || ne !== 0 || frame_addr !== 4'h3) begin
            n_bad++; $display("FAIL rst_new: dac_d=%h valid=%0d err=%0d addr=%h want 555/1/0/3",
                              dac_d, nv, ne, frame_addr);
        end
    endtask

    task automatic run_random(input int nframes, input int window);
        int nv, ne, lat;
        logic [31:0] r, w;
        logic [3:0]  c, a;
        for (int f = 0; f < nframes; f++) begin
            r = $urandom();
            case ($urandom_range(0, 6))
                0: c = 4'd0;  1: c = 4'd1;  2: c = 4'd2;  3: c = 4'd3;
                4: c = 4'd4;  5: c = 4'hF;  default: c = 4'($urandom_range(0, 15));
            endcase
            case ($urandom_range(0, 5))
                0: a = 4'd0;  1: a = 4'd1;  2: a = 4'd2;  3: a = 4'd3;
                4: a = 4'hF;  default: a = 4'($urandom_range(0, 15));
            endcase
            if (c == 4'd2 && a != 4'hF && a > 4'd3) a = a & 4'd3;
            w = {r[31:24], c, a, r[15:0]};
            model_apply(w);
            send_frame(w, 32, window, nv, ne, lat);
            n_cmp++;
            if (nv !== 1 || ne !== 0 || frame_data !== w[15:4] || frame_cmd !== c) begin
                n_bad++; $display("FAIL rnd%0d_frame: valid=%0d err=%0d cmd=%h data=%h want 1/0/%h/%h",
                                  f, nv, ne, frame_cmd, frame_data, c, w[15:4]);
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (dac_arr[i] !== out_m[i]) begin
                    n_bad++; $display("FAIL rnd%0d_dac%0d: got %h want %h (word %h)",
                                      f, i, dac_arr[i], out_m[i], w);
                end
            end
            n_cmp++;
            if (pd_mask !== pd_m) begin
                n_bad++; $display("FAIL rnd%0d_pd: got %b want %b (word %h)", f, pd_mask, pd_m, w);
            end
        end
    endtask

    task automatic test_random();
        run_random(40, 12);
    endtask

    task automatic test_back_to_back();
        run_random(6, 6);
    endtask

    initial begin
        test_reset();
        test_write_update();
        test_input_then_update();
        test_all_powerdown();
        test_bad_frames();
        test_clear();
        test_reset_midframe();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
